// File: rtl/ev_toeplitz_hash_engine_if.sv
// Handshake and result bundle for the Toeplitz hash engine.
// master = controller / stream sources side, slave = hash engine side.
interface ev_toeplitz_hash_engine_if #(
  parameter int W     = 64,
  parameter int K     = 64,
  parameter int LEN_W = 16
);
  logic             start;
  logic [LEN_W-1:0] key_words;
  logic [K-1:0]     ref_tag;
  logic             abort;
  logic             rnd_valid;
  logic [W-1:0]     rnd_data;
  logic             rnd_ready;
  logic             key_valid;
  logic [W-1:0]     key_data;
  logic             key_ready;
  logic             busy;
  logic [K-1:0]     hash_tag;
  logic             tag_valid;
  logic             tag_match;
  logic             err;

  modport master (
    output start, key_words, ref_tag, abort,
    output rnd_valid, rnd_data, key_valid, key_data,
    input  rnd_ready, key_ready, busy, hash_tag, tag_valid, tag_match, err
  );

  modport slave (
    input  start, key_words, ref_tag, abort,
    input  rnd_valid, rnd_data, key_valid, key_data,
    output rnd_ready, key_ready, busy, hash_tag, tag_valid, tag_match, err
  );
endinterface

// File: rtl/ev_toeplitz_hash_engine.sv
// Self-sequencing Toeplitz hash engine: primes a random-bit window, then
// folds each key word against a sliding window of the random stream into a
// K-bit GF(2) accumulator, and finally compares the tag with a peer tag.
module ev_toeplitz_hash_engine #(
  parameter int W     = 64,
  parameter int K     = 64,
  parameter int LEN_W = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  ev_toeplitz_hash_engine_if.slave bus
);
  localparam int P    = (K - 1 + W - 1) / W;
  localparam int WIN  = K + W - 1;
  localparam int PC_W = $clog2(P + 1);

  typedef enum logic [1:0] {IDLE, PRIME, HASH, DONE} state_t;

  state_t state_reg, state_next;

  // The logical window is WIN bits wide, but its top W bits are always
  // shifted out before they are read, so only the low K-1 bits are stored.
  logic [K-2:0]     win_reg;
  logic [WIN-1:0]   win_next;
  logic [K-1:0]     acc_reg;
  logic [K-1:0]     acc_next;
  logic [LEN_W-1:0] remain_reg;
  logic [PC_W-1:0]  prime_reg;
  logic [K-1:0]     ref_reg;
  logic [K-1:0]     tag_reg;
  logic             match_reg;
  logic             tag_valid_reg;
  logic             err_reg;

  logic prime_beat;
  logic hash_beat;
  logic start_ok;
  logic start_bad;
  logic last_prime;
  logic last_hash;

  // Window after shifting in the current random word (new bits at the LSBs).
  assign win_next = {win_reg, bus.rnd_data};

  // Each tag bit j is the parity of the key word against window bits j..j+W-1.
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_acc
      assign acc_next[gi] = acc_reg[gi] ^ (^(win_next[gi +: W] & bus.key_data));
    end
  endgenerate

  // Abort suppresses every transfer in the cycle it is asserted.
  assign prime_beat = (state_reg == PRIME) && bus.rnd_valid && !bus.abort;
  assign hash_beat  = (state_reg == HASH) && bus.rnd_valid && bus.key_valid && !bus.abort;
  assign start_ok   = (state_reg == IDLE) && bus.start && !bus.abort && (bus.key_words != '0);
  assign start_bad  = (state_reg == IDLE) && bus.start && !bus.abort && (bus.key_words == '0);
  assign last_prime = (prime_reg == PC_W'(1));
  assign last_hash  = (remain_reg == LEN_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; abort always returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = PRIME;
      PRIME:   if (prime_beat && last_prime) state_next = HASH;
      HASH:    if (hash_beat && last_hash) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.abort) begin
      state_next = IDLE;
    end
  end

  // Output decode: readies in HASH depend only on the opposite valid.
  always_comb begin
    bus.rnd_ready = 1'b0;
    bus.key_ready = 1'b0;
    if (!bus.abort) begin
      case (state_reg)
        PRIME: bus.rnd_ready = 1'b1;
        HASH: begin
          bus.rnd_ready = bus.key_valid;
          bus.key_ready = bus.rnd_valid;
        end
        default: begin
          bus.rnd_ready = 1'b0;
          bus.key_ready = 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = (state_reg != IDLE);
  assign bus.hash_tag  = tag_reg;
  assign bus.tag_match = match_reg;
  assign bus.tag_valid = tag_valid_reg;
  assign bus.err       = err_reg;

  // Datapath: window shift, accumulation, counters and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_reg       <= '0;
      acc_reg       <= '0;
      remain_reg    <= '0;
      prime_reg     <= '0;
      ref_reg       <= '0;
      tag_reg       <= '0;
      match_reg     <= 1'b0;
      tag_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      tag_valid_reg <= 1'b0;
      err_reg       <= start_bad;
      if (bus.abort) begin
        win_reg <= '0;
        acc_reg <= '0;
      end else begin
        if (start_ok) begin
          win_reg    <= '0;
          acc_reg    <= '0;
          remain_reg <= bus.key_words;
          ref_reg    <= bus.ref_tag;
          prime_reg  <= PC_W'(P);
        end
        if (prime_beat) begin
          win_reg   <= win_next[K-2:0];
          prime_reg <= prime_reg - PC_W'(1);
        end
        if (hash_beat) begin
          win_reg    <= win_next[K-2:0];
          acc_reg    <= acc_next;
          remain_reg <= remain_reg - LEN_W'(1);
          // Result is registered on the last beat so it appears with the DONE pulse.
          if (last_hash) begin
            tag_reg       <= acc_next;
            match_reg     <= (acc_next == ref_reg);
            tag_valid_reg <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ev_toeplitz_hash_engine.sv
// Bench for the Toeplitz hash engine: a small W=K=4 instance for the fixed
// vectors and a default W=K=64 instance checked against a direct-index model.
module tb_ev_toeplitz_hash_engine;
  logic clk;
  logic rst_n;

  int compared;
  int mismatched;

  logic [63:0] rnd_mem [0:31];
  logic [63:0] key_mem [0:31];
  logic [63:0] key_a   [0:31];
  logic [63:0] key_b   [0:31];

  ev_toeplitz_hash_engine_if #(.W(64), .K(64), .LEN_W(16)) bb ();
  ev_toeplitz_hash_engine_if #(.W(4),  .K(4),  .LEN_W(16)) sb ();

  ev_toeplitz_hash_engine #(.W(64), .K(64), .LEN_W(16)) dut_big (
    .clk(clk), .rst_n(rst_n), .bus(bb)
  );
  ev_toeplitz_hash_engine #(.W(4), .K(4), .LEN_W(16)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toeplitz tag from first principles: for key beat s the random window is
  // the bit string of words 0..1+s (word 0 primes), bit b taken from word
  // (1+s - b/64) at position b%64; bits before the stream start are zero.
  function automatic logic [63:0] model_tag(input int len);
    logic [63:0] t;
    int b;
    int m;
    t = '0;
    for (int s = 0; s < len; s++) begin
      for (int j = 0; j < 64; j++) begin
        for (int i = 0; i < 64; i++) begin
          b = j + i;
          m = 1 + s - b / 64;
          if (key_mem[s][i] && m >= 0 && rnd_mem[m][b % 64]) t[j] = ~t[j];
        end
      end
    end
    return t;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 32; i++) begin
      rnd_mem[i] = {$urandom, $urandom};
      key_mem[i] = {$urandom, $urandom};
    end
  endtask

  // Drives one hash on the 64-bit instance. cut_kind 1 aborts and 2 resets
  // asynchronously once cut_at hash beats have been accepted.
  // seq = {tag_valid seen early, tag_valid 1 cycle after last beat,
  //        tag_valid 2 cycles after, busy 2 cycles after}.
  task automatic drive_hash(input int len, input logic [63:0] rtag, input bit stall,
                            input int cut_at, input int cut_kind,
                            output logic [63:0] tag, output logic match,
                            output logic [3:0] seq, output logic [5:0] snap,
                            output logic [63:0] snap_tag, output bit timeout);
    int pr;
    int hb;
    int cyc;
    bit rv;
    bit kv;
    bit rf;
    bit kf;
    tag = '0; match = 1'b0; seq = '0; snap = '0; snap_tag = '0; timeout = 1'b0;
    @(negedge clk);
    bb.start = 1'b1; bb.key_words = 16'(len); bb.ref_tag = rtag;
    @(negedge clk);
    bb.start = 1'b0;
    pr = 0; hb = 0; cyc = 0;
    while (hb < len && cyc < 3000) begin
      if (cut_kind != 0 && pr == 1 && hb == cut_at) break;
      rv = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      kv = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      bb.rnd_valid = rv;
      bb.key_valid = kv;
      bb.rnd_data  = rv ? rnd_mem[pr + hb] : {$urandom, $urandom};
      bb.key_data  = (kv && pr == 1) ? key_mem[hb] : {$urandom, $urandom};
      #1;
      rf = rv && bb.rnd_ready;
      kf = kv && bb.key_ready;
      if (bb.tag_valid) seq[3] = 1'b1;
      @(posedge clk);
      if (pr < 1) begin
        if (rf) pr++;
      end else if (rf && kf) begin
        hb++;
      end
      cyc++;
      @(negedge clk);
    end
    bb.rnd_valid = 1'b0;
    bb.key_valid = 1'b0;
    if (cut_kind == 1) begin
      bb.abort = 1'b1; bb.rnd_valid = 1'b1; bb.key_valid = 1'b1;
      bb.rnd_data = rnd_mem[1 + hb]; bb.key_data = key_mem[hb];
      #1;
      snap[5] = bb.rnd_ready;
      snap[4] = bb.key_ready;
      @(negedge clk);
      bb.abort = 1'b0; bb.rnd_valid = 1'b0; bb.key_valid = 1'b0;
      snap[3] = bb.busy;
      for (int c = 0; c < 4; c++) begin
        if (bb.tag_valid) snap[2] = 1'b1;
        @(negedge clk);
      end
      snap_tag = bb.hash_tag;
    end else if (cut_kind == 2) begin
      bb.rnd_valid = 1'b1; bb.key_valid = 1'b1;
      bb.rnd_data = rnd_mem[1 + hb]; bb.key_data = key_mem[hb];
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      snap = {bb.rnd_ready, bb.key_ready, bb.busy, bb.tag_valid, bb.tag_match, bb.err};
      snap_tag = bb.hash_tag;
      bb.rnd_valid = 1'b0; bb.key_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end else if (hb < len) begin
      timeout = 1'b1;
    end else begin
      seq[2]   = bb.tag_valid;
      tag      = bb.hash_tag;
      match    = bb.tag_match;
      @(negedge clk);
      seq[1]   = bb.tag_valid;
      seq[0]   = bb.busy;
    end
  endtask

  // Fixed single-beat vector on the 4-bit instance.
  task automatic run_small(input logic [3:0] kd, input logic [3:0] rt,
                           output logic [3:0] tag, output logic m, output logic [1:0] tv);
    @(negedge clk);
    sb.start = 1'b1; sb.key_words = 16'd1; sb.ref_tag = rt;
    @(negedge clk);
    sb.start = 1'b0; sb.rnd_valid = 1'b1; sb.rnd_data = 4'b0001; sb.key_valid = 1'b0;
    @(negedge clk);
    sb.rnd_data = 4'b0000; sb.key_valid = 1'b1; sb.key_data = kd;
    @(negedge clk);
    sb.rnd_valid = 1'b0; sb.key_valid = 1'b0;
    tv[1] = sb.tag_valid; tag = sb.hash_tag; m = sb.tag_match;
    @(negedge clk);
    tv[0] = sb.tag_valid;
  endtask

  task automatic test_reset();
    #12;
    compared++;
    if ({bb.busy, bb.rnd_ready, bb.key_ready, bb.tag_valid, bb.tag_match, bb.err} !== 6'b0
        || bb.hash_tag !== 64'h0) begin
      mismatched++;
      $display("FAIL reset_big: got flags %b tag %h want 0", {bb.busy, bb.rnd_ready,
               bb.key_ready, bb.tag_valid, bb.tag_match, bb.err}, bb.hash_tag);
    end
    compared++;
    if ({sb.busy, sb.rnd_ready, sb.key_ready, sb.tag_valid, sb.tag_match, sb.err} !== 6'b0
        || sb.hash_tag !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_small: got flags %b tag %h want 0", {sb.busy, sb.rnd_ready,
               sb.key_ready, sb.tag_valid, sb.tag_match, sb.err}, sb.hash_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: outputs checked during reset");
  endtask

  task automatic test_small_vectors();
    logic [3:0] tag;
    logic m;
    logic [1:0] tv;
    run_small(4'b1000, 4'b0010, tag, m, tv);
    $display("small: key=1000 tag=%b match=%b tv=%b", tag, m, tv);
    compared++;
    if (tag !== 4'b0010) begin
      mismatched++; $display("FAIL small_tag_a: got %b want 0010", tag);
    end
    compared++;
    if (m !== 1'b1) begin
      mismatched++; $display("FAIL small_match_a: got %b want 1", m);
    end
    compared++;
    if (tv !== 2'b10) begin
      mismatched++; $display("FAIL small_pulse_a: got %b want 10", tv);
    end
    run_small(4'b0001, 4'b0010, tag, m, tv);
    $display("small: key=0001 tag=%b match=%b tv=%b", tag, m, tv);
    compared++;
    if (tag !== 4'b0000) begin
      mismatched++; $display("FAIL small_tag_b: got %b want 0000", tag);
    end
    compared++;
    if (m !== 1'b0 || tv !== 2'b10) begin
      mismatched++; $display("FAIL small_match_b: got match %b pulse %b want 0 10", m, tv);
    end
  endtask

  task automatic test_random_stall();
    logic [63:0] exp_t;
    logic [63:0] t0;
    logic [63:0] t1;
    logic [63:0] st;
    logic m0;
    logic m1;
    logic [3:0] sq0;
    logic [3:0] sq1;
    logic [5:0] sn;
    bit to0;
    bit to1;
    for (int r = 0; r < 3; r++) begin
      fill_random();
      exp_t = model_tag(16);
      drive_hash(16, exp_t, 1'b0, 0, 0, t0, m0, sq0, sn, st, to0);
      drive_hash(16, exp_t ^ 64'h1, 1'b1, 0, 0, t1, m1, sq1, sn, st, to1);
      $display("stall run %0d: nostall=%h stall=%h model=%h", r, t0, t1, exp_t);
      compared++;
      if (to0 || to1) begin
        mismatched++; $display("FAIL stall_timeout: got %b%b want 00", to0, to1);
      end
      compared++;
      if (t0 !== exp_t) begin
        mismatched++; $display("FAIL nostall_tag: got %h want %h", t0, exp_t);
      end
      compared++;
      if (t1 !== exp_t) begin
        mismatched++; $display("FAIL stall_tag: got %h want %h", t1, exp_t);
      end
      compared++;
      if (m0 !== 1'b1 || m1 !== 1'b0) begin
        mismatched++; $display("FAIL stall_match: got %b%b want 10", m0, m1);
      end
      compared++;
      if (sq0 !== 4'b0100 || sq1 !== 4'b0100) begin
        mismatched++; $display("FAIL stall_pulse: got %b %b want 0100", sq0, sq1);
      end
    end
  endtask

  task automatic test_linearity();
    logic [63:0] ta;
    logic [63:0] tb2;
    logic [63:0] tx;
    logic [63:0] st;
    logic m;
    logic [3:0] sq;
    logic [5:0] sn;
    bit to;
    fill_random();
    for (int i = 0; i < 32; i++) begin
      key_a[i] = key_mem[i];
      key_b[i] = {$urandom, $urandom};
    end
    drive_hash(16, 64'h0, 1'b1, 0, 0, ta, m, sq, sn, st, to);
    for (int i = 0; i < 32; i++) key_mem[i] = key_b[i];
    drive_hash(16, 64'h0, 1'b1, 0, 0, tb2, m, sq, sn, st, to);
    compared++;
    if (tb2 !== model_tag(16)) begin
      mismatched++; $display("FAIL lin_tag_b: got %h want %h", tb2, model_tag(16));
    end
    for (int i = 0; i < 32; i++) key_mem[i] = key_a[i] ^ key_b[i];
    drive_hash(16, 64'h0, 1'b1, 0, 0, tx, m, sq, sn, st, to);
    $display("linearity: ta=%h tb=%h txor=%h", ta, tb2, tx);
    compared++;
    if (tx !== (ta ^ tb2)) begin
      mismatched++; $display("FAIL linearity: got %h want %h", tx, ta ^ tb2);
    end
  endtask

  task automatic test_err();
    logic [2:0] rd;
    @(negedge clk);
    bb.start = 1'b1; bb.key_words = 16'd0; bb.rnd_valid = 1'b1; bb.key_valid = 1'b1;
    #1;
    rd[2] = bb.rnd_ready | bb.key_ready;
    @(negedge clk);
    bb.start = 1'b0;
    #1;
    rd[1] = bb.err;
    rd[0] = bb.busy | bb.rnd_ready | bb.key_ready;
    @(negedge clk);
    bb.rnd_valid = 1'b0; bb.key_valid = 1'b0;
    $display("err: ready_at_start=%b err=%b busy_or_ready=%b", rd[2], rd[1], rd[0]);
    compared++;
    if (rd !== 3'b010) begin
      mismatched++; $display("FAIL err_pulse: got %b want 010", rd);
    end
    compared++;
    if (bb.err !== 1'b0 || bb.busy !== 1'b0) begin
      mismatched++; $display("FAIL err_after: got err %b busy %b want 0 0", bb.err, bb.busy);
    end
  endtask

  task automatic test_abort();
    logic [63:0] exp_t;
    logic [63:0] t;
    logic [63:0] st;
    logic m;
    logic [3:0] sq;
    logic [5:0] sn;
    bit to;
    logic [1:0] rd;
    fill_random();
    exp_t = model_tag(8);
    drive_hash(8, exp_t, 1'b0, 0, 0, t, m, sq, sn, st, to);
    for (int i = 0; i < 8; i++) key_mem[i] = {$urandom, $urandom};
    drive_hash(8, 64'h0, 1'b1, 3, 1, t, m, sq, sn, st, to);
    $display("abort: snap=%b held_tag=%h", sn, st);
    compared++;
    if (sn !== 6'b0) begin
      mismatched++; $display("FAIL abort_flags: got %b want 000000", sn);
    end
    compared++;
    if (st !== exp_t) begin
      mismatched++; $display("FAIL abort_tag_held: got %h want %h", st, exp_t);
    end
    exp_t = model_tag(8);
    drive_hash(8, exp_t, 1'b1, 0, 0, t, m, sq, sn, st, to);
    $display("abort: rerun tag=%h model=%h", t, exp_t);
    compared++;
    if (t !== exp_t || m !== 1'b1 || to) begin
      mismatched++; $display("FAIL abort_rerun: got %h m=%b want %h m=1", t, m, exp_t);
    end
    @(negedge clk);
    bb.start = 1'b1; bb.abort = 1'b1; bb.key_words = 16'd4;
    #1;
    rd[1] = bb.rnd_ready | bb.key_ready;
    @(negedge clk);
    bb.start = 1'b0; bb.abort = 1'b0;
    rd[0] = bb.busy;
    @(negedge clk);
    $display("abort+start: ready=%b busy=%b", rd[1], rd[0]);
    compared++;
    if (rd !== 2'b00 || bb.busy !== 1'b0 || bb.err !== 1'b0) begin
      mismatched++; $display("FAIL abort_start_idle: got %b busy %b err %b want 00 0 0",
                             rd, bb.busy, bb.err);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] exp_t;
    logic [63:0] t;
    logic [63:0] st;
    logic m;
    logic [3:0] sq;
    logic [5:0] sn;
    bit to;
    fill_random();
    exp_t = model_tag(16);
    drive_hash(16, exp_t, 1'b0, 0, 0, t, m, sq, sn, st, to);
    drive_hash(16, 64'h0, 1'b1, 5, 2, t, m, sq, sn, st, to);
    $display("async reset: snap=%b tag=%h", sn, st);
    compared++;
    if (sn !== 6'b0 || st !== 64'h0) begin
      mismatched++; $display("FAIL async_reset: got flags %b tag %h want 0", sn, st);
    end
    drive_hash(16, exp_t, 1'b1, 0, 0, t, m, sq, sn, st, to);
    $display("async reset: rerun tag=%h model=%h", t, exp_t);
    compared++;
    if (t !== exp_t || m !== 1'b1 || sq !== 4'b0100 || to) begin
      mismatched++; $display("FAIL reset_rerun: got %h m=%b seq=%b want %h m=1 seq=0100",
                             t, m, sq, exp_t);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst_n = 1'b0;
    bb.start = 1'b0; bb.key_words = '0; bb.ref_tag = '0; bb.abort = 1'b0;
    bb.rnd_valid = 1'b0; bb.rnd_data = '0; bb.key_valid = 1'b0; bb.key_data = '0;
    sb.start = 1'b0; sb.key_words = '0; sb.ref_tag = '0; sb.abort = 1'b0;
    sb.rnd_valid = 1'b0; sb.rnd_data = '0; sb.key_valid = 1'b0; sb.key_data = '0;
    test_reset();
    test_small_vectors();
    test_random_stall();
    test_linearity();
    test_err();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ev_toeplitz_hash_engine.md
Name: ev_toeplitz_hash_engine

Overview:
Parametrised, self-sequencing Toeplitz hash engine for QKD error verification. It primes a random-bit window, streams a reconciled key of run-time length against a matching random stream, and produces a K-bit hash tag. It also compares the tag against a peer reference tag. It sits between the error-reconciliation key buffer / random source and the EV packet logic, and replaces the fixed 64x64 shift-enable/key-enable hashing datapath with its own FSM and valid/ready handshakes.

Parameters:
W, 64, key/random word width per beat (W>=1)
K, 64, hash tag width (K>=2)
LEN_W, 16, width of key-length field in words
P (localparam), ceil((K-1)/W), number of priming random words
WIN (localparam), K+W-1, random window width in bits

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin new hash; sampled in IDLE only
key_words  in  LEN_W  number of key beats for this hash, sampled with start
ref_tag  in  K  peer tag to compare, sampled with start
abort  in  1  cancel current hash
rnd_valid  in  1  random word valid
rnd_data  in  W  random word
rnd_ready  out  1  random word accepted when rnd_valid&&rnd_ready
key_valid  in  1  key word valid
key_data  in  W  key word
key_ready  out  1  key word accepted when key_valid&&key_ready
busy  out  1  state != IDLE
hash_tag  out  K  final tag, held until next accepted start
tag_valid  out  1  one-cycle pulse: hash_tag/tag_match valid
tag_match  out  1  hash_tag == sampled ref_tag, held with hash_tag
err  out  1  one-cycle pulse: start with key_words==0

Behaviour:
- Reset (async, rst_n low): state IDLE; window, accumulator, counters, ref register cleared; hash_tag=0, tag_valid=0, tag_match=0, err=0, busy=0, rnd_ready=0, key_ready=0.
- States: IDLE, PRIME, HASH, DONE.
- IDLE: start && key_words!=0 -> clear window and accumulator, latch key_words and ref_tag, load prime counter with P -> PRIME. start && key_words==0 -> err=1 next cycle, stay IDLE. Outside IDLE, start is ignored.
- PRIME: rnd_ready=1, key_ready=0. Each random beat: win <= {win[WIN-1-W:0], rnd_data}. If W>=WIN, the low WIN bits of rnd_data are used. After the P-th beat -> HASH.
- HASH: a beat occurs only when both streams are valid. rnd_ready = key_valid; key_ready = rnd_valid; both are 0 outside HASH/PRIME as stated. Readies depend combinationally on the opposite valid; there is no combinational path from ready to valid.
- Per HASH beat: win_n = shift of win with rnd_data as above. win <= win_n. For each j in 0..K-1: acc[j] <= acc[j] ^ (^(win_n[j +: W] & key_data)). Remaining count decrements.
- On the last HASH beat (count reaches 0): go to DONE. The next cycle: hash_tag <= final acc, tag_match <= (final acc == ref), tag_valid=1 for exactly one cycle, then IDLE. Latency: tag_valid is asserted 1 cycle after the last accepted beat.
- Stalls (either valid low) freeze all state. Bubbles are allowed at any point.
- abort (any state): return to IDLE next cycle. Window and accumulator are cleared, no tag_valid is issued, and hash_tag/tag_match keep their previous values. abort has priority over start and over a same-cycle beat; that beat is not accepted (readies forced 0 while abort=1).
- A new start is accepted the cycle after DONE (IDLE), so back-to-back hashes have a 1-cycle gap.
- Arithmetic is GF(2) only. The tag is linear in the key for a fixed random stream.

Test Plan:
- W=4,K=4 (P=1), start key_words=1; prime rnd=4'b0001; beat rnd=4'b0000,key=4'b1000 -> tag_valid pulse 1 cycle after beat, hash_tag=4'b0010; with ref_tag=4'b0010, tag_match=1.
- Same stimulus with key=4'b0001 -> hash_tag=4'b0000; ref_tag=4'b0010 gives tag_match=0.
- Defaults W=K=64, key_words=16, random stalls on both valids: hash_tag equals the software Toeplitz model and equals the no-stall run. Linearity: tag(k1^k2)=tag(k1)^tag(k2) under the same random stream.
- start with key_words=0 -> err pulse 1 cycle, busy stays 0, no readies asserted.
- abort during HASH after 3 of 8 beats -> IDLE next cycle, no tag_valid, hash_tag unchanged. A following full run produces the correct tag. abort+start in IDLE -> stays IDLE.
- rst_n asserted mid-HASH (asynchronous, between clock edges) -> all outputs 0 immediately. start after release yields the correct tag.
